// File: rtl/t_ff_toggle_ctrl.sv
// Toggle-enable sequencer for a T flip-flop: periodic pulses, finite bursts,
// and a stop that always parks the flip-flop at q=0.
module t_ff_toggle_ctrl #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               t_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] toggles
);

  typedef enum logic [1:0] {IDLE, RUN, PARK} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, hp_q, hp_d, hp_sel;
  logic [BURST_W-1:0] bl_q, bl_d, tog_q, tog_d, tog_inc;
  logic               t_q, t_d, busy_q, busy_d, done_q, done_d;

  assign hp_sel  = (half_period == '0) ? CNT_W'(1) : half_period;
  assign tog_inc = tog_q + BURST_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    bl_d    = bl_q;
    tog_d   = tog_q;
    busy_d  = busy_q;
    t_d     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          hp_d    = hp_sel;
          bl_d    = burst_len;
          cnt_d   = hp_sel - CNT_W'(1);
          tog_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // An odd pulse count leaves q=1, so one corrective pulse is owed.
        if (stop) begin
          if (tog_q[0]) state_d = PARK;
          else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == '0) begin
          t_d   = 1'b1;
          tog_d = tog_inc;
          cnt_d = hp_q - CNT_W'(1);
          if (bl_q != '0 && tog_inc == bl_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PARK: begin
        t_d     = 1'b1;
        tog_d   = tog_inc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      bl_q    <= '0;
      tog_q   <= '0;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      bl_q    <= bl_d;
      tog_q   <= tog_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign t_out   = t_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign toggles = tog_q;

endmodule

// File: tb/tb_t_ff_toggle_ctrl.sv
// Bench for t_ff_toggle_ctrl: elapsed-time reference model plus a real T
// flip-flop on t_out to confirm the parked output level.
module tb_t_ff_toggle_ctrl;
  localparam int CNT_W = 8, BURST_W = 8;

  logic clk = 0, reset = 1, start = 0, stop = 0;
  logic [CNT_W-1:0]   half_period = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic t_out, busy, done;
  logic [BURST_W-1:0] toggles;

  int n_tests = 0, n_fail = 0;

  t_ff_toggle_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .half_period(half_period), .burst_len(burst_len),
    .t_out(t_out), .busy(busy), .done(done), .toggles(toggles));

  always #5 clk = ~clk;

  // Flip-flop being driven by the controller.
  logic ff_q;
  always @(posedge clk or posedge reset)
    if (reset) ff_q <= 1'b0;
    else       ff_q <= ff_q ^ t_out;

  // Reference model: pulses fall where elapsed run time is a multiple of hp.
  localparam int M_IDLE = 0, M_RUN = 1, M_PARK = 2;
  int   m_mode = M_IDLE, m_hp = 1, m_bl = 0, m_el = 0, m_n = 0;
  logic m_t = 0, m_busy = 0, m_done = 0, m_par = 0;
  logic [BURST_W-1:0] m_tog;
  assign m_tog = m_n[BURST_W-1:0];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_t = 0; m_busy = 0; m_done = 0; m_n = 0; m_par = 0;
    end else begin
      m_par  = m_par ^ m_t;
      m_done = 0;
      m_t    = 0;
      if (m_mode == M_IDLE) begin
        if (start && !stop) begin
          m_hp = (half_period == 0) ? 1 : int'(half_period);
          m_bl = int'(burst_len);
          m_el = 0; m_n = 0; m_busy = 1; m_mode = M_RUN;
        end
      end else if (m_mode == M_RUN) begin
        if (stop) begin
          if (m_n % 2 == 1) m_mode = M_PARK;
          else begin m_busy = 0; m_mode = M_IDLE; end
        end else begin
          m_el++;
          if (m_el % m_hp == 0) begin
            m_t = 1; m_n++;
            if (m_bl != 0 && m_n == m_bl) begin
              m_busy = 0; m_done = 1; m_mode = M_IDLE;
            end
          end
        end
      end else begin
        m_t = 1; m_n++; m_done = 1; m_busy = 0; m_mode = M_IDLE;
      end
    end
  end

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({t_out, busy, done, toggles} !== '0) begin
      n_fail++;
      $display("FAIL reset: got t/b/d/tog=%b/%b/%b/%0d want all 0", t_out, busy, done, toggles);
    end
    reset = 0;
  endtask

  task automatic test_burst();
    half_period = 3; burst_len = 4; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); n_tests++;
      if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
        n_fail++;
        $display("FAIL burst c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
      end
    end
    n_tests++;
    if ({busy, toggles, ff_q} !== {1'b0, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL burst_end: got busy=%b tog=%0d q=%b want 0/4/0", busy, toggles, ff_q);
    end
  endtask

  task automatic test_continuous_hp0();
    half_period = 0; burst_len = 0; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); n_tests++;
      if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
        n_fail++;
        $display("FAIL hp0 c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
      end
    end
    n_tests++;
    if ({t_out, busy, toggles} !== {1'b1, 1'b1, 8'd12}) begin
      n_fail++;
      $display("FAIL hp0_steady: got t=%b busy=%b tog=%0d want 1/1/12", t_out, busy, toggles);
    end
    stop = 1;
    repeat (3) @(negedge clk);
    stop = 0;
    @(negedge clk); n_tests++;
    if ({busy, ff_q} !== {1'b0, m_par}) begin
      n_fail++;
      $display("FAIL hp0_stop: got busy=%b q=%b want 0/%b", busy, ff_q, m_par);
    end
  endtask

  // Stop after npulse pulses at hp=2; returns final toggles/done for directed checks.
  task automatic run_stop(input int npulse, input string nm);
    half_period = 2; burst_len = 0; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 40 && m_n < npulse; c++) @(negedge clk);
    n_tests++;
    if (m_n != npulse) begin
      n_fail++;
      $display("FAIL %s_wait: model reached %0d pulses, wanted %0d", nm, m_n, npulse);
    end
    stop = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); n_tests++;
      if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
        n_fail++;
        $display("FAIL %s c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 nm, c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
      end
    end
    stop = 0;
    @(negedge clk);
  endtask

  task automatic test_stop_odd();
    logic saw_done;
    half_period = 2; burst_len = 0; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 40 && m_n < 3; c++) @(negedge clk);
    stop = 1;
    @(negedge clk); n_tests++;
    if ({t_out, busy, done} !== 3'b010) begin
      n_fail++;
      $display("FAIL stop_odd_edge: got t/b/d=%b%b%b want 010", t_out, busy, done);
    end
    @(negedge clk); saw_done = done; n_tests++;
    if ({t_out, busy, saw_done, toggles} !== {1'b1, 1'b0, 1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL stop_odd_park: got t/b/d/tog=%b/%b/%b/%0d want 1/0/1/4", t_out, busy, saw_done, toggles);
    end
    stop = 0;
    @(negedge clk); n_tests++;
    if ({done, ff_q} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_odd_q: got done=%b q=%b want 0/0", done, ff_q);
    end
  endtask

  task automatic test_stop_even();
    run_stop(2, "stop_even");
    n_tests++;
    if ({busy, toggles, ff_q} !== {1'b0, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_even_end: got busy=%b tog=%0d q=%b want 0/2/0", busy, toggles, ff_q);
    end
  endtask

  task automatic test_start_held();
    half_period = 3; burst_len = 0; start = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); n_tests++;
      if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
        n_fail++;
        $display("FAIL held c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
      end
      if (c == 4) half_period = 1;
    end
    n_tests++;
    if (toggles !== 8'd4) begin
      n_fail++;
      $display("FAIL held_spacing: got tog=%0d want 4", toggles);
    end
    start = 0; stop = 1;
    repeat (3) @(negedge clk);
    // Both requests high in IDLE: stop must win.
    start = 1;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({busy, t_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_stop_idle: got busy=%b t=%b want 0/0", busy, t_out);
    end
    start = 0; stop = 0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    half_period = 3; burst_len = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    @(posedge clk); #2 reset = 1;
    #1 n_tests++;
    if ({t_out, busy, done, toggles} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got t/b/d/tog=%b/%b/%b/%0d want all 0", t_out, busy, done, toggles);
    end
    @(negedge clk); reset = 0;
    half_period = 2; burst_len = 2; start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); n_tests++;
      if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
        n_fail++;
        $display("FAIL post_reset c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
      end
    end
  endtask

  task automatic test_wrap();
    half_period = 1; burst_len = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (259) @(negedge clk);
    n_tests++;
    if ({toggles, busy} !== {m_tog, 1'b1} || toggles !== 8'd3) begin
      n_fail++;
      $display("FAIL wrap: got tog=%0d busy=%b want 3/1", toggles, busy);
    end
    stop = 1; repeat (3) @(negedge clk); stop = 0;
    @(negedge clk); n_tests++;
    if (ff_q !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_park: got q=%b want 0", ff_q);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      half_period = CNT_W'($urandom_range(0, 4));
      burst_len   = BURST_W'($urandom_range(0, 5));
      for (int c = 0; c < 40; c++) begin
        @(negedge clk); n_tests++;
        if ({t_out, busy, done, toggles} !== {m_t, m_busy, m_done, m_tog}) begin
          n_fail++;
          $display("FAIL random r%0d c%0d: got t/b/d/tog=%b/%b/%b/%0d want %b/%b/%b/%0d",
                   r, c, t_out, busy, done, toggles, m_t, m_busy, m_done, m_tog);
        end
        if (m_mode == M_IDLE && !m_t) begin
          n_tests++;
          if (ff_q !== m_par) begin
            n_fail++;
            $display("FAIL random_q r%0d c%0d: got q=%b want %b", r, c, ff_q, m_par);
          end
        end
        start = ($urandom % 3) == 0;
        stop  = ($urandom % 12) == 0;
        if (c == 20) half_period = CNT_W'($urandom_range(0, 4));
      end
      start = 0; stop = 1;
      repeat (3) @(negedge clk);
      stop = 0;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_continuous_hp0();
    test_stop_odd();
    test_stop_even();
    test_start_held();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/t_ff_toggle_ctrl.md
# t_ff_toggle_ctrl

Sequencer that drives the `t` input of one T flip-flop (or a bank sharing one enable) to generate programmable-rate toggling, finite toggle bursts, and a clean parked stop. It sits between software/config logic and the flip-flop. The flip-flop output becomes a divided clock or square wave of period 2×half_period cycles. On stop, the controller always returns the flip-flop to q=0.

## Interface
Parameters:
- CNT_W, 8, width of the half-period counter
- BURST_W, 8, width of the burst length and toggle count

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level-sampled start request; honoured only in IDLE
- stop  in  1  level-sampled stop request; honoured in RUN
- half_period  in  CNT_W  cycles between toggle pulses; 0 is treated as 1
- burst_len  in  BURST_W  number of toggles to emit; 0 means continuous
- t_out  out  1  registered toggle enable; connect to the flip-flop `t`
- busy  out  1  registered; high in RUN and PARK
- done  out  1  registered single-cycle pulse at burst completion or park completion
- toggles  out  BURST_W  registered count of pulses emitted in the current or last run

## Operation
- Reset (asynchronous): state=IDLE; t_out=0, busy=0, done=0, toggles=0; internal counter=0.
- States:
  - IDLE: no pulses.
  - RUN: periodic pulses.
  - PARK: emits one corrective pulse.
- Default each edge: done<=0.
- IDLE, start=1 and stop=0:
  - Latch hp = max(half_period,1) and bl = burst_len.
  - Set cnt<=hp-1, toggles<=0, busy<=1, state<=RUN.
- IDLE, start=1 and stop=1: stop wins; remain in IDLE, no change.
- RUN, each edge, evaluated in priority order:
  1. stop=1 and toggles odd: t_out<=0, state<=PARK.
  2. stop=1 and toggles even: t_out<=0, busy<=0, state<=IDLE. No done.
  3. cnt==0: t_out<=1, toggles<=toggles+1, cnt<=hp-1. If bl!=0 and toggles+1==bl: state<=IDLE, busy<=0, done<=1.
  4. Otherwise: t_out<=0, cnt<=cnt-1.
- PARK, next edge: t_out<=1, toggles<=toggles+1, done<=1, busy<=0, state<=IDLE. stop and start are ignored in PARK.
- IDLE: t_out<=0 every edge. toggles holds its last value until the next accepted start.
- start while in RUN or PARK is ignored.
- half_period and burst_len are sampled only on an accepted start. Changes mid-run have no effect.
- Arithmetic:
  - cnt is unsigned CNT_W.
  - toggles wraps modulo 2^BURST_W in continuous mode.
  - Parity is taken from toggles[0].
  - A burst with odd bl leaves the flip-flop at q=1; no park pulse is issued.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start accepted at edge k: the first t_out pulse is registered at edge k+hp. Subsequent pulses follow every hp edges.
- hp=1: t_out stays high every cycle from edge k+1; the flip-flop divides clk by 2.
- Flip-flop output period is 2×hp cycles (50% duty).
- Burst end: the last t_out pulse and done are high in the same cycle; busy falls in that same cycle.
- Stop sampled at edge s:
  - t_out is low from edge s.
  - Odd toggles: a single park pulse with done at edge s+1; busy low from s+1.
  - Even toggles: busy low from edge s.
- Reset asserted mid-run: outputs go to 0 immediately, with no park pulse. The flip-flop is reset by the same reset net.
- Earliest restart: a start sampled on the edge after done/IDLE entry.

## Test plan
- hp=3, bl=4, start at edge 0 -> t_out high after edges 3,6,9,12. done with the 4th pulse; toggles=4; busy low after edge 12; flip-flop q ends 0.
- half_period=0, bl=0 -> t_out continuously high from edge 1; flip-flop q toggles every cycle; busy stays 1.
- hp=2, bl=0, stop asserted after 3 pulses -> no pulse on the stop edge. One park pulse plus done on the next edge; toggles=4; q=0.
- hp=2, bl=0, stop after 2 pulses -> IDLE immediately, no done, toggles=2, q=0.
- Start held high during RUN, and half_period changed mid-run -> no restart, pulse spacing unchanged. start and stop both high in IDLE -> remains IDLE.
- Reset asserted asynchronously mid-cycle during RUN -> t_out, busy, done, toggles go to 0 before the next edge. Next start behaves as after power-up.
